// File: rtl/decode_stage.sv
// Y86 decode stage: register-ID decode, E/M/W forwarding onto valA/valB,
// load-use hazard detection and the D->E pipeline register.
module decode_stage #(
  parameter int DATA_WID = 64,
  parameter int ADDR_WID = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                D_valid,
  input  logic [3:0]          D_icode,
  input  logic [3:0]          D_ifun,
  input  logic [ADDR_WID-1:0] D_rA,
  input  logic [ADDR_WID-1:0] D_rB,
  input  logic [DATA_WID-1:0] D_valC,
  input  logic [DATA_WID-1:0] D_valP,
  output logic [ADDR_WID-1:0] srcA,
  output logic [ADDR_WID-1:0] srcB,
  input  logic [DATA_WID-1:0] rf_valA,
  input  logic [DATA_WID-1:0] rf_valB,
  input  logic [ADDR_WID-1:0] e_dstE,
  input  logic [DATA_WID-1:0] e_valE,
  input  logic [ADDR_WID-1:0] M_dstE,
  input  logic [DATA_WID-1:0] M_valE,
  input  logic [ADDR_WID-1:0] M_dstM,
  input  logic [DATA_WID-1:0] m_valM,
  input  logic [ADDR_WID-1:0] W_dstE,
  input  logic [DATA_WID-1:0] W_valE,
  input  logic [ADDR_WID-1:0] W_dstM,
  input  logic [DATA_WID-1:0] W_valM,
  input  logic                E_flush,
  output logic                stall_FD,
  output logic                E_valid,
  output logic [3:0]          E_icode,
  output logic [3:0]          E_ifun,
  output logic [DATA_WID-1:0] E_valC,
  output logic [DATA_WID-1:0] E_valA,
  output logic [DATA_WID-1:0] E_valB,
  output logic [ADDR_WID-1:0] E_dstE,
  output logic [ADDR_WID-1:0] E_dstM,
  output logic [ADDR_WID-1:0] E_srcA,
  output logic [ADDR_WID-1:0] E_srcB
);

  localparam logic [ADDR_WID-1:0] RNONE = '1;
  localparam logic [ADDR_WID-1:0] RSP   = ADDR_WID'(4);

  localparam logic [3:0] IC_NOP   = 4'h1;
  localparam logic [3:0] IC_RRMOV = 4'h2;
  localparam logic [3:0] IC_IRMOV = 4'h3;
  localparam logic [3:0] IC_RMMOV = 4'h4;
  localparam logic [3:0] IC_MRMOV = 4'h5;
  localparam logic [3:0] IC_OPQ   = 4'h6;
  localparam logic [3:0] IC_JXX   = 4'h7;
  localparam logic [3:0] IC_CALL  = 4'h8;
  localparam logic [3:0] IC_RET   = 4'h9;
  localparam logic [3:0] IC_PUSH  = 4'hA;
  localparam logic [3:0] IC_POP   = 4'hB;

  typedef struct packed {
    logic                valid;
    logic [3:0]          icode;
    logic [3:0]          ifun;
    logic [DATA_WID-1:0] valC;
    logic [DATA_WID-1:0] valA;
    logic [DATA_WID-1:0] valB;
    logic [ADDR_WID-1:0] dstE;
    logic [ADDR_WID-1:0] dstM;
    logic [ADDR_WID-1:0] srcA;
    logic [ADDR_WID-1:0] srcB;
  } e_bundle_t;

  logic [ADDR_WID-1:0] w_srcA, w_srcB, w_dstE, w_dstM;
  logic [DATA_WID-1:0] w_valA, w_valB;
  logic                w_loaduse;
  e_bundle_t           w_bubble, w_decoded;
  e_bundle_t           r_e;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    if (D_valid) begin
      case (D_icode)
        IC_RRMOV, IC_RMMOV, IC_OPQ, IC_PUSH: w_srcA = D_rA;
        IC_RET, IC_POP:                      w_srcA = RSP;
        default:                             w_srcA = RNONE;
      endcase
      case (D_icode)
        IC_RMMOV, IC_MRMOV, IC_OPQ:          w_srcB = D_rB;
        IC_CALL, IC_RET, IC_PUSH, IC_POP:    w_srcB = RSP;
        default:                             w_srcB = RNONE;
      endcase
      case (D_icode)
        IC_RRMOV, IC_IRMOV, IC_OPQ:          w_dstE = D_rB;
        IC_CALL, IC_RET, IC_PUSH, IC_POP:    w_dstE = RSP;
        default:                             w_dstE = RNONE;
      endcase
      case (D_icode)
        IC_MRMOV, IC_POP:                    w_dstM = D_rA;
        default:                             w_dstM = RNONE;
      endcase
    end
  end

  // Youngest producer wins; RNONE sources never match a destination.
  always_comb begin
    w_valA = rf_valA;
    if (D_icode == IC_JXX || D_icode == IC_CALL) w_valA = D_valP;
    else if (w_srcA != RNONE) begin
      if      (w_srcA == e_dstE) w_valA = e_valE;
      else if (w_srcA == M_dstM) w_valA = m_valM;
      else if (w_srcA == M_dstE) w_valA = M_valE;
      else if (w_srcA == W_dstM) w_valA = W_valM;
      else if (w_srcA == W_dstE) w_valA = W_valE;
    end
  end

  always_comb begin
    w_valB = rf_valB;
    if (w_srcB != RNONE) begin
      if      (w_srcB == e_dstE) w_valB = e_valE;
      else if (w_srcB == M_dstM) w_valB = m_valM;
      else if (w_srcB == M_dstE) w_valB = M_valE;
      else if (w_srcB == W_dstM) w_valB = W_valM;
      else if (w_srcB == W_dstE) w_valB = W_valE;
    end
  end

  assign w_loaduse = r_e.valid
                  && (r_e.icode == IC_MRMOV || r_e.icode == IC_POP)
                  && (r_e.dstM != RNONE)
                  && (r_e.dstM == w_srcA || r_e.dstM == w_srcB);

  always_comb begin
    w_bubble       = '0;
    w_bubble.icode = IC_NOP;
    w_bubble.dstE  = RNONE;
    w_bubble.dstM  = RNONE;
    w_bubble.srcA  = RNONE;
    w_bubble.srcB  = RNONE;
  end

  always_comb begin
    w_decoded.valid = D_valid;
    w_decoded.icode = D_icode;
    w_decoded.ifun  = D_ifun;
    w_decoded.valC  = D_valC;
    w_decoded.valA  = w_valA;
    w_decoded.valB  = w_valB;
    w_decoded.dstE  = w_dstE;
    w_decoded.dstM  = w_dstM;
    w_decoded.srcA  = w_srcA;
    w_decoded.srcB  = w_srcB;
  end

  always_ff @(posedge CLK) begin
    if (RST)                       r_e <= w_bubble;
    else if (E_flush || w_loaduse) r_e <= w_bubble;
    else                           r_e <= w_decoded;
  end

  assign srcA     = w_srcA;
  assign srcB     = w_srcB;
  assign stall_FD = w_loaduse;

  assign E_valid = r_e.valid;
  assign E_icode = r_e.icode;
  assign E_ifun  = r_e.ifun;
  assign E_valC  = r_e.valC;
  assign E_valA  = r_e.valA;
  assign E_valB  = r_e.valB;
  assign E_dstE  = r_e.dstE;
  assign E_dstM  = r_e.dstM;
  assign E_srcA  = r_e.srcA;
  assign E_srcB  = r_e.srcB;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: each driven cycle pushes its expected E
// bundle, a monitor pops and compares it after the following clock edge.
module tb_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } e_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        D_valid;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  srcA, srcB;
  logic [63:0] rf_valA, rf_valB;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic        E_flush;
  logic        stall_FD;
  logic        E_valid;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

  e_t sb[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  decode_stage #(.DATA_WID(64), .ADDR_WID(4)) dut (
    .CLK(CLK), .RST(RST),
    .D_valid(D_valid), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .srcA(srcA), .srcB(srcB), .rf_valA(rf_valA), .rf_valB(rf_valB),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .E_flush(E_flush), .stall_FD(stall_FD),
    .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  always @(posedge CLK) begin
    e_t exp_e;
    e_t got_e;
    #1;
    if (sb.size() > 0) begin
      exp_e = sb.pop_front();
      got_e = {E_valid, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB};
      total_cnt++;
      if (got_e !== exp_e)
        $display("FAIL e_bundle @%0t: got %h expected %h", $time, got_e, exp_e);
      else pass_cnt++;
    end
  end

  function automatic e_t mk(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                            input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] de, input logic [3:0] dm,
                            input logic [3:0] sa, input logic [3:0] sbb);
    mk = {v, ic, fn, c, a, b, de, dm, sa, sbb};
  endfunction

  function automatic e_t bub();
    bub = mk(1'b0, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
  endfunction

  task automatic cycle(input e_t exp_e);
    sb.push_back(exp_e);
    @(posedge CLK);
    #2;
  endtask

  task automatic set_idle();
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0;   M_valE = '0;   m_valM = '0;   W_valE = '0;   W_valM = '0;
    rf_valA = '0;  rf_valB = '0;  E_flush = 1'b0;
  endtask

  task automatic set_d(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] c, input logic [63:0] p);
    D_valid = v; D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb; D_valC = c; D_valP = p;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    set_idle();
    set_d(1'b1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h9, 64'h9);
    rf_valA = 64'h11; rf_valB = 64'h22;
    cycle(bub());
    cycle(bub());
    total_cnt++;
    if (stall_FD !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_FD);
    else pass_cnt++;
    total_cnt++;
    if (E_icode !== 4'h1) $display("FAIL reset_icode: got %h expected 1", E_icode);
    else pass_cnt++;
    RST = 1'b0;
  endtask

  task automatic test_opq();
    set_idle();
    set_d(1'b1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h1234, 64'h99);
    rf_valA = 64'h11; rf_valB = 64'h22;
    #1;
    total_cnt++;
    if (srcA !== 4'h2 || srcB !== 4'h3)
      $display("FAIL opq_srcs: got %h/%h expected 2/3", srcA, srcB);
    else pass_cnt++;
    cycle(mk(1'b1, 4'h6, 4'h0, 64'h1234, 64'h11, 64'h22, 4'h3, 4'hF, 4'h2, 4'h3));
  endtask

  task automatic test_forward();
    set_idle();
    set_d(1'b1, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h0);
    rf_valA = 64'h11; rf_valB = 64'h22;
    e_dstE = 4'h2; e_valE = 64'hAA; W_dstE = 4'h2; W_valE = 64'hBB;
    M_dstM = 4'h3; m_valM = 64'h33; M_dstE = 4'h3; M_valE = 64'h44;
    #1;
    total_cnt++;
    if (stall_FD !== 1'b0) $display("FAIL fwd_no_stall: got %b expected 0", stall_FD);
    else pass_cnt++;
    cycle(mk(1'b1, 4'h6, 4'h1, 64'h0, 64'hAA, 64'h33, 4'h3, 4'hF, 4'h2, 4'h3));

    set_idle();
    rf_valA = 64'h11; rf_valB = 64'h22;
    W_dstM = 4'h2; W_valM = 64'hC1; W_dstE = 4'h2; W_valE = 64'hC2;
    M_dstE = 4'h3; M_valE = 64'h44;
    cycle(mk(1'b1, 4'h6, 4'h1, 64'h0, 64'hC1, 64'h44, 4'h3, 4'hF, 4'h2, 4'h3));

    set_idle();
    rf_valA = 64'h11; rf_valB = 64'h22;
    M_dstE = 4'h2; M_valE = 64'h4E; W_dstE = 4'h3; W_valE = 64'hE3;
    cycle(mk(1'b1, 4'h6, 4'h1, 64'h0, 64'h4E, 64'hE3, 4'h3, 4'hF, 4'h2, 4'h3));
  endtask

  task automatic test_loaduse();
    set_idle();
    set_d(1'b1, 4'h5, 4'h0, 4'h5, 4'h6, 64'h10, 64'h0);
    rf_valA = 64'h77; rf_valB = 64'h60;
    cycle(mk(1'b1, 4'h5, 4'h0, 64'h10, 64'h77, 64'h60, 4'hF, 4'h5, 4'hF, 4'h6));

    set_idle();
    set_d(1'b1, 4'h6, 4'h0, 4'h5, 4'h3, 64'h0, 64'h0);
    rf_valA = 64'h11; rf_valB = 64'h22;
    #1;
    total_cnt++;
    if (stall_FD !== 1'b1) $display("FAIL lu_stall_srcA: got %b expected 1", stall_FD);
    else pass_cnt++;
    cycle(bub());

    M_dstM = 4'h5; m_valM = 64'h55;
    #1;
    total_cnt++;
    if (stall_FD !== 1'b0) $display("FAIL lu_release: got %b expected 0", stall_FD);
    else pass_cnt++;
    cycle(mk(1'b1, 4'h6, 4'h0, 64'h0, 64'h55, 64'h22, 4'h3, 4'hF, 4'h5, 4'h3));

    set_idle();
    set_d(1'b1, 4'hB, 4'h0, 4'h7, 4'hF, 64'h0, 64'h0);
    rf_valA = 64'h1000; rf_valB = 64'h1000;
    cycle(mk(1'b1, 4'hB, 4'h0, 64'h0, 64'h1000, 64'h1000, 4'h4, 4'h7, 4'h4, 4'h4));

    set_idle();
    set_d(1'b1, 4'h4, 4'h0, 4'h1, 4'h7, 64'h8, 64'h0);
    rf_valA = 64'h1; rf_valB = 64'h2;
    #1;
    total_cnt++;
    if (stall_FD !== 1'b1) $display("FAIL lu_stall_srcB: got %b expected 1", stall_FD);
    else pass_cnt++;
    cycle(bub());

    M_dstM = 4'h7; m_valM = 64'h70;
    cycle(mk(1'b1, 4'h4, 4'h0, 64'h8, 64'h1, 64'h70, 4'hF, 4'hF, 4'h1, 4'h7));
  endtask

  task automatic test_call_push();
    set_idle();
    set_d(1'b1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h40);
    rf_valA = 64'h3; rf_valB = 64'h800;
    #1;
    total_cnt++;
    if (srcA !== 4'hF || srcB !== 4'h4)
      $display("FAIL call_srcs: got %h/%h expected F/4", srcA, srcB);
    else pass_cnt++;
    cycle(mk(1'b1, 4'h8, 4'h0, 64'h200, 64'h40, 64'h800, 4'h4, 4'hF, 4'hF, 4'h4));

    set_idle();
    set_d(1'b1, 4'hA, 4'h0, 4'hF, 4'hF, 64'h0, 64'h50);
    rf_valA = 64'h5; rf_valB = 64'h900; e_valE = 64'hDEAD;
    #1;
    total_cnt++;
    if (srcA !== 4'hF) $display("FAIL push_srcA: got %h expected F", srcA);
    else pass_cnt++;
    cycle(mk(1'b1, 4'hA, 4'h0, 64'h0, 64'h5, 64'h900, 4'h4, 4'hF, 4'hF, 4'h4));

    set_idle();
    set_d(1'b1, 4'h7, 4'h3, 4'hF, 4'hF, 64'h300, 64'h88);
    rf_valA = 64'h6; rf_valB = 64'h7;
    cycle(mk(1'b1, 4'h7, 4'h3, 64'h300, 64'h88, 64'h7, 4'hF, 4'hF, 4'hF, 4'hF));

    set_idle();
    set_d(1'b0, 4'h6, 4'h0, 4'h2, 4'h3, 64'h5, 64'h6);
    rf_valA = 64'h12; rf_valB = 64'h34; e_dstE = 4'h2; e_valE = 64'hAA;
    #1;
    total_cnt++;
    if (srcA !== 4'hF || srcB !== 4'hF)
      $display("FAIL invalid_srcs: got %h/%h expected F/F", srcA, srcB);
    else pass_cnt++;
    cycle(mk(1'b0, 4'h6, 4'h0, 64'h5, 64'h12, 64'h34, 4'hF, 4'hF, 4'hF, 4'hF));
  endtask

  task automatic test_flush();
    set_idle();
    set_d(1'b1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
    rf_valA = 64'h11; rf_valB = 64'h22; E_flush = 1'b1;
    cycle(bub());

    set_idle();
    set_d(1'b1, 4'h5, 4'h0, 4'h5, 4'h6, 64'h10, 64'h0);
    rf_valA = 64'h77; rf_valB = 64'h60;
    cycle(mk(1'b1, 4'h5, 4'h0, 64'h10, 64'h77, 64'h60, 4'hF, 4'h5, 4'hF, 4'h6));

    set_idle();
    set_d(1'b1, 4'h6, 4'h0, 4'h5, 4'h3, 64'h0, 64'h0);
    rf_valA = 64'h11; rf_valB = 64'h22; E_flush = 1'b1;
    #1;
    total_cnt++;
    if (stall_FD !== 1'b1) $display("FAIL flush_lu_stall: got %b expected 1", stall_FD);
    else pass_cnt++;
    cycle(bub());

    E_flush = 1'b0; M_dstM = 4'h5; m_valM = 64'h55;
    cycle(mk(1'b1, 4'h6, 4'h0, 64'h0, 64'h55, 64'h22, 4'h3, 4'hF, 4'h5, 4'h3));
  endtask

  task automatic test_back_to_back();
    set_idle();
    set_d(1'b1, 4'h3, 4'h0, 4'hF, 4'h9, 64'h123, 64'h0);
    rf_valA = 64'h1; rf_valB = 64'h2;
    cycle(mk(1'b1, 4'h3, 4'h0, 64'h123, 64'h1, 64'h2, 4'h9, 4'hF, 4'hF, 4'hF));

    set_d(1'b1, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
    rf_valA = 64'hAB; e_dstE = 4'h1; e_valE = 64'h111;
    cycle(mk(1'b1, 4'h2, 4'h0, 64'h0, 64'h111, 64'h2, 4'h2, 4'hF, 4'h1, 4'hF));

    set_idle();
    RST = 1'b1;
    set_d(1'b1, 4'h6, 4'h2, 4'h2, 4'h3, 64'h0, 64'h0);
    rf_valA = 64'h11; rf_valB = 64'h22;
    cycle(bub());
    RST = 1'b0;
    #1;
    total_cnt++;
    if (stall_FD !== 1'b0 || E_valid !== 1'b0)
      $display("FAIL midreset: got stall=%b valid=%b expected 0/0", stall_FD, E_valid);
    else pass_cnt++;
    cycle(mk(1'b1, 4'h6, 4'h2, 64'h0, 64'h11, 64'h22, 4'h3, 4'hF, 4'h2, 4'h3));
  endtask

  initial begin
    test_reset();
    test_opq();
    test_forward();
    test_loaduse();
    test_call_push();
    test_flush();
    test_back_to_back();
    set_idle();
    set_d(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    @(negedge CLK);
    total_cnt++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
